// File: rtl/imem_port_arbiter_if.sv
// Bundle of the two requester ports, the jump flush and the ROM port.
// The arbiter uses the slave view; the fetch units, flush source and ROM
// together form the master view.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              flush_i;
  logic              p0_valid_i;
  logic [ADDR_W-1:0] p0_addr_i;
  logic              p0_ready_o;
  logic              p0_ok_o;
  logic [DATA_W-1:0] p0_data_o;
  logic              p0_err_o;
  logic              p1_valid_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic              p1_ready_o;
  logic              p1_ok_o;
  logic [DATA_W-1:0] p1_data_o;
  logic              p1_err_o;
  logic              mem_request_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              mem_dataOk_i;
  logic              busy_o;

  modport slave (
    input  flush_i,
    input  p0_valid_i, p0_addr_i,
    output p0_ready_o, p0_ok_o, p0_data_o, p0_err_o,
    input  p1_valid_i, p1_addr_i,
    output p1_ready_o, p1_ok_o, p1_data_o, p1_err_o,
    output mem_request_o, mem_addr_o,
    input  mem_data_i, mem_dataOk_i,
    output busy_o
  );

  modport master (
    output flush_i,
    output p0_valid_i, p0_addr_i,
    input  p0_ready_o, p0_ok_o, p0_data_o, p0_err_o,
    output p1_valid_i, p1_addr_i,
    input  p1_ready_o, p1_ok_o, p1_data_o, p1_err_o,
    input  mem_request_o, mem_addr_o,
    output mem_data_i, mem_dataOk_i,
    input  busy_o
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Two-requester arbiter for the single instruction-ROM port.
// One transaction in flight, round-robin grant, jump flush cancels port-0
// traffic, and a silent memory is answered with an error after TIMEOUT cycles.
module imem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input logic                clk,
  input logic                reset_n,
  imem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  // The counter is compared against TIMEOUT-1 because the response is
  // registered: the error pulse then lands exactly TIMEOUT cycles after
  // the memory request.  ">=" covers a WAIT->DROP hop on the last cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic              owner_reg;       // 0: port 0 owns the transaction, 1: port 1
  logic              last_grant_reg;
  logic [7:0]        count_reg;
  logic              mem_request_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              p0_ok_reg, p1_ok_reg;
  logic              p0_err_reg, p1_err_reg;
  logic [DATA_W-1:0] p0_data_reg, p1_data_reg;

  logic p0_cand, p1_cand, win0, win1;
  logic p0_ready, p1_ready, accept;
  logic flush_hit, timeout_hit;
  logic resp_fire, resp_err;

  // Arbitration candidates: a flush removes port 0 from contention.
  assign p0_cand     = bus.p0_valid_i & ~bus.flush_i;
  assign p1_cand     = bus.p1_valid_i;
  assign win0        = p0_cand & (~p1_cand | last_grant_reg);
  assign win1        = p1_cand & (~p0_cand | ~last_grant_reg);
  assign flush_hit   = bus.flush_i & ~owner_reg;
  assign timeout_hit = (count_reg >= TIMEOUT_LAST);
  assign accept      = p0_ready | p1_ready;

  // Next-state, ready and response-strobe decode.
  always_comb begin
    state_next = state_reg;
    p0_ready   = 1'b0;
    p1_ready   = 1'b0;
    resp_fire  = 1'b0;
    resp_err   = 1'b0;
    case (state_reg)
      IDLE: begin
        p0_ready = win0;
        p1_ready = win1;
        if (win0 | win1) state_next = WAIT;
      end
      WAIT: begin
        if (bus.mem_dataOk_i) begin
          state_next = IDLE;
          resp_fire  = ~flush_hit;
        end else if (flush_hit) begin
          state_next = DROP;
        end else if (timeout_hit) begin
          state_next = IDLE;
          resp_fire  = 1'b1;
          resp_err   = 1'b1;
        end
      end
      DROP: begin
        if (bus.mem_dataOk_i | timeout_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Grant bookkeeping, memory request pulse and latched address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_reg       <= 1'b0;
      last_grant_reg  <= 1'b1;
      mem_request_reg <= 1'b0;
      mem_addr_reg    <= '0;
    end else begin
      mem_request_reg <= accept;
      if (accept) begin
        owner_reg      <= p1_ready;
        last_grant_reg <= p1_ready;
        mem_addr_reg   <= p1_ready ? bus.p1_addr_i : bus.p0_addr_i;
      end
    end
  end

  // Cycle counter for the timeout; restarts on every accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                count_reg <= '0;
    else if (accept)             count_reg <= '0;
    else if (state_reg != IDLE)  count_reg <= count_reg + 8'd1;
  end

  // Response registers: one-cycle ok pulse, data/err held until next response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0_ok_reg   <= 1'b0;
      p1_ok_reg   <= 1'b0;
      p0_err_reg  <= 1'b0;
      p1_err_reg  <= 1'b0;
      p0_data_reg <= '0;
      p1_data_reg <= '0;
    end else begin
      p0_ok_reg <= resp_fire & ~owner_reg;
      p1_ok_reg <= resp_fire & owner_reg;
      if (resp_fire & ~owner_reg) begin
        p0_data_reg <= resp_err ? '0 : bus.mem_data_i;
        p0_err_reg  <= resp_err;
      end
      if (resp_fire & owner_reg) begin
        p1_data_reg <= resp_err ? '0 : bus.mem_data_i;
        p1_err_reg  <= resp_err;
      end
    end
  end

  assign bus.p0_ready_o    = p0_ready;
  assign bus.p1_ready_o    = p1_ready;
  assign bus.p0_ok_o       = p0_ok_reg;
  assign bus.p1_ok_o       = p1_ok_reg;
  assign bus.p0_err_o      = p0_err_reg;
  assign bus.p1_err_o      = p1_err_reg;
  assign bus.p0_data_o     = p0_data_reg;
  assign bus.p1_data_o     = p1_data_reg;
  assign bus.mem_request_o = mem_request_reg;
  assign bus.mem_addr_o    = mem_addr_reg;
  assign bus.busy_o        = (state_reg != IDLE);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter: directed stimulus pushes the
// expected responses, an independent monitor pops them on every ok pulse.
module tb_imem_port_arbiter;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  imem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic        port;
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t sb[$];
  resp_t mon_exp;
  logic  mon_port;
  int    checks = 0;
  int    errors = 0;

  function automatic resp_t mk(input logic p, input logic [31:0] d, input logic e);
    resp_t r;
    r.port = p;
    r.data = d;
    r.err  = e;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a request, wait (bounded) for the grant, return in the request cycle.
  task automatic issue(input bit port, input logic [31:0] addr);
    int n;
    n = 0;
    if (port) begin bus.p1_valid_i = 1'b1; bus.p1_addr_i = addr; end
    else      begin bus.p0_valid_i = 1'b1; bus.p0_addr_i = addr; end
    #1;
    while (!(port ? bus.p1_ready_o : bus.p0_ready_o) && n < 20) begin
      tick();
      n++;
    end
    check("ready", 32'(port ? bus.p1_ready_o : bus.p0_ready_o), 32'd1);
    tick();
    bus.p0_valid_i = 1'b0;
    bus.p1_valid_i = 1'b0;
    check("mem_request", 32'(bus.mem_request_o), 32'd1);
    check("mem_addr", bus.mem_addr_o, addr);
  endtask

  // Memory answers after gap cycles; returns in the cycle ok is expected.
  task automatic reply(input int gap, input logic [31:0] data);
    repeat (gap) tick();
    bus.mem_dataOk_i = 1'b1;
    bus.mem_data_i   = data;
    tick();
    bus.mem_dataOk_i = 1'b0;
  endtask

  // Monitor: every ok pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (reset_n && (bus.p0_ok_o || bus.p1_ok_o)) begin
      check("single_ok", 32'(bus.p0_ok_o & bus.p1_ok_o), 32'd0);
      mon_port = bus.p1_ok_o;
      $display("resp port=%0d data=%h err=%0b", mon_port,
               mon_port ? bus.p1_data_o : bus.p0_data_o,
               mon_port ? bus.p1_err_o : bus.p0_err_o);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ok port=%0d required=no response", mon_port);
      end else begin
        mon_exp = sb.pop_front();
        check("resp_port", 32'(mon_port), 32'(mon_exp.port));
        check("resp_data", mon_port ? bus.p1_data_o : bus.p0_data_o, mon_exp.data);
        check("resp_err", 32'(mon_port ? bus.p1_err_o : bus.p0_err_o), 32'(mon_exp.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rr_addr [4];
    logic [31:0] rr_data [4];
    logic        rr_port;
    rr_addr = '{32'h200, 32'h280, 32'h204, 32'h284};
    rr_data = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};

    bus.flush_i      = 1'b0;
    bus.p0_valid_i   = 1'b0;
    bus.p0_addr_i    = '0;
    bus.p1_valid_i   = 1'b0;
    bus.p1_addr_i    = '0;
    bus.mem_data_i   = '0;
    bus.mem_dataOk_i = 1'b0;
    reset_n          = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_mem_request", 32'(bus.mem_request_o), 32'd0);
    check("rst_mem_addr", bus.mem_addr_o, 32'd0);
    check("rst_p0_ok", 32'(bus.p0_ok_o), 32'd0);
    check("rst_p1_ok", 32'(bus.p1_ok_o), 32'd0);
    check("rst_p0_data", bus.p0_data_o, 32'd0);
    check("rst_p1_err", 32'(bus.p1_err_o), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Round robin with both ports always valid: p0, p1, p0, p1.
    bus.p0_valid_i = 1'b1; bus.p0_addr_i = 32'h200;
    bus.p1_valid_i = 1'b1; bus.p1_addr_i = 32'h280;
    #1;
    for (int i = 0; i < 4; i++) begin
      rr_port = (i % 2) == 1;
      check("rr_p0_ready", 32'(bus.p0_ready_o), 32'(!rr_port));
      check("rr_p1_ready", 32'(bus.p1_ready_o), 32'(rr_port));
      sb.push_back(mk(rr_port, rr_data[i], 1'b0));
      tick();
      check("rr_mem_addr", bus.mem_addr_o, rr_addr[i]);
      if (rr_port) bus.p1_addr_i = 32'h284;
      else         bus.p0_addr_i = 32'h204;
      bus.mem_dataOk_i = 1'b1;
      bus.mem_data_i   = rr_data[i];
      tick();
      bus.mem_dataOk_i = 1'b0;
    end
    bus.p0_valid_i = 1'b0;
    bus.p1_valid_i = 1'b0;
    tick();

    // Single p0 read at minimum latency.
    sb.push_back(mk(1'b0, 32'hDEAD_BEEF, 1'b0));
    issue(1'b0, 32'h100);
    reply(0, 32'hDEAD_BEEF);
    check("min_lat_ok", 32'(bus.p0_ok_o), 32'd1);
    check("min_lat_idle", 32'(bus.busy_o), 32'd0);
    tick();
    check("ok_one_cycle", 32'(bus.p0_ok_o), 32'd0);
    check("data_hold", bus.p0_data_o, 32'hDEAD_BEEF);

    // Flush two cycles before dataOk: dropped silently.
    issue(1'b0, 32'h300);
    tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    check("drop_busy", 32'(bus.busy_o), 32'd1);
    tick();
    bus.mem_dataOk_i = 1'b1;
    bus.mem_data_i   = 32'hBAD0_0001;
    check("drop_busy_dataok", 32'(bus.busy_o), 32'd1);
    tick();
    bus.mem_dataOk_i = 1'b0;
    check("drop_done", 32'(bus.busy_o), 32'd0);
    sb.push_back(mk(1'b0, 32'hCAFE_0304, 1'b0));
    issue(1'b0, 32'h304);
    reply(0, 32'hCAFE_0304);
    check("after_drop_ok", 32'(bus.p0_ok_o), 32'd1);
    tick();

    // Flush coincident with dataOk, owner p0: suppressed.
    issue(1'b0, 32'h400);
    bus.flush_i      = 1'b1;
    bus.mem_dataOk_i = 1'b1;
    bus.mem_data_i   = 32'hBAD0_0002;
    tick();
    bus.flush_i      = 1'b0;
    bus.mem_dataOk_i = 1'b0;
    check("flush_coinc_idle", 32'(bus.busy_o), 32'd0);
    check("flush_coinc_p0_ok", 32'(bus.p0_ok_o), 32'd0);

    // Same with owner p1: delivered normally.
    sb.push_back(mk(1'b1, 32'h55AA_0500, 1'b0));
    issue(1'b1, 32'h500);
    bus.flush_i      = 1'b1;
    bus.mem_dataOk_i = 1'b1;
    bus.mem_data_i   = 32'h55AA_0500;
    tick();
    bus.flush_i      = 1'b0;
    bus.mem_dataOk_i = 1'b0;
    check("flush_p1_ok", 32'(bus.p1_ok_o), 32'd1);
    check("flush_p1_idle", 32'(bus.busy_o), 32'd0);
    tick();

    // Silent memory: error response exactly TO cycles after the request.
    sb.push_back(mk(1'b0, 32'h0, 1'b1));
    issue(1'b0, 32'h600);
    repeat (TO - 1) tick();
    check("to_early_ok", 32'(bus.p0_ok_o), 32'd0);
    check("to_early_busy", 32'(bus.busy_o), 32'd1);
    tick();
    check("to_ok", 32'(bus.p0_ok_o), 32'd1);
    check("to_err", 32'(bus.p0_err_o), 32'd1);
    check("to_data", bus.p0_data_o, 32'd0);
    check("to_idle", 32'(bus.busy_o), 32'd0);
    tick();

    // Reset in WAIT, then a stale dataOk after release.
    issue(1'b1, 32'h700);
    tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    check("mid_rst_mem_addr", bus.mem_addr_o, 32'd0);
    check("mid_rst_mem_request", 32'(bus.mem_request_o), 32'd0);
    check("mid_rst_p1_data", bus.p1_data_o, 32'd0);
    check("mid_rst_p0_err", 32'(bus.p0_err_o), 32'd0);
    tick();
    reset_n          = 1'b1;
    bus.mem_dataOk_i = 1'b1;
    bus.mem_data_i   = 32'hBAD0_0003;
    tick();
    bus.mem_dataOk_i = 1'b0;
    check("stale_busy", 32'(bus.busy_o), 32'd0);
    repeat (2) tick();
    check("stale_p1_ok", 32'(bus.p1_ok_o), 32'd0);

    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single instruction-ROM port (request / address / data / dataOk) between two requesters.
  - Port 0: the front-fetch stage.
  - Port 1: a secondary requester (debug / data-side read).
- Sits between the fetch units and the test ROM.
- Keeps one transaction outstanding at a time and arbitrates round-robin.
- Cancels in-flight fetch traffic on a jump flush and times out a silent memory.

Parameters:
- ADDR_W, 32, address width of requesters and memory.
- DATA_W, 32, data width of returned word.
- TIMEOUT, 64, cycles waited for mem_dataOk_i before an error response (range 2..255).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush_i  input  1  jump flush (driven by jumpFlag); cancels port-0 traffic only.
- p0_valid_i  input  1  port-0 read request.
- p0_addr_i  input  ADDR_W  port-0 address.
- p0_ready_o  output  1  port-0 request accepted this cycle.
- p0_ok_o  output  1  port-0 response pulse.
- p0_data_o  output  DATA_W  port-0 response data.
- p0_err_o  output  1  port-0 response is a timeout error.
- p1_valid_i  input  1  port-1 read request.
- p1_addr_i  input  ADDR_W  port-1 address.
- p1_ready_o  output  1  port-1 request accepted this cycle.
- p1_ok_o  output  1  port-1 response pulse.
- p1_data_o  output  DATA_W  port-1 response data.
- p1_err_o  output  1  port-1 response is a timeout error.
- mem_request_o  output  1  one-cycle request pulse to memory.
- mem_addr_o  output  ADDR_W  memory address, held from request until response.
- mem_data_i  input  DATA_W  memory read data.
- mem_dataOk_i  input  1  memory data valid.
- busy_o  output  1  state is not IDLE.

Behaviour:
- Reset values:
  - state = IDLE, last_grant = 1 (port 0 wins first), counter = 0.
  - All outputs 0, including data and address.
- Handshake:
  - A request is accepted when pX_valid_i and pX_ready_o are both 1 in the same cycle.
  - pX_ready_o is combinational: 1 only when state == IDLE and port X is the arbitration winner.
  - Requesters hold valid and address until accepted.
- Arbitration (IDLE only):
  - Only one port valid: that port wins.
  - Both valid: the port not equal to last_grant wins.
  - last_grant updates on accept.
  - p0 is never a candidate while flush_i = 1.
- Accept edge:
  - Latch owner and address into mem_addr_o.
  - mem_request_o = 1 for exactly the next cycle.
  - Counter clears; state goes to WAIT.
- WAIT:
  - Counter increments each cycle; mem_dataOk_i sampled each cycle.
  - On dataOk (no flush on owner): next cycle the owner's ok_o = 1 for one cycle, data_o = mem_data_i, err_o = 0; state goes to IDLE.
  - data_o holds its value until the next response on that port.
  - Minimum latency: accept at cycle T, mem_request_o at T+1, dataOk at T+1 at earliest, ok_o at T+2.
  - Back-to-back: a new accept is possible in the same cycle ok_o is high.
- Flush:
  - flush_i in WAIT with owner = 0:
    - dataOk in the same cycle: response is suppressed and state goes to IDLE.
    - otherwise: state goes to DROP.
  - Flush with owner = 1 has no effect.
  - Flush in the cycle p0_ok_o is already high does not retract the pulse.
- DROP:
  - Wait for mem_dataOk_i, discard it, go to IDLE; no ok pulse on either port.
  - Further flushes are ignored.
- Timeout:
  - Counter reaching TIMEOUT in WAIT: owner gets ok_o = 1, err_o = 1, data_o = 0; state goes to IDLE.
  - Counter reaching TIMEOUT in DROP: go to IDLE silently.
  - mem_dataOk_i in IDLE is ignored; memory must not respond after a timeout.
- Asynchronous reset mid-transaction:
  - Everything returns to reset values immediately; the outstanding transaction is abandoned.
  - No ok pulse is emitted after reset deassertion.
- busy_o = (state != IDLE).

Test Plan:
- Single p0 read of 0x100, memory dataOk 1 cycle after request with data 0xDEADBEEF -> mem_request_o high at T+1 with mem_addr_o = 0x100; p0_ok_o high at T+2 with p0_data_o = 0xDEADBEEF, p0_err_o = 0.
- p0 and p1 both continuously valid for 4 transactions -> grants alternate p0, p1, p0, p1; each ok on the matching port only.
- p0 in WAIT, flush_i pulsed 2 cycles before dataOk -> state DROP, no p0_ok_o/p1_ok_o, busy_o falls the cycle after dataOk; a new p0 request is then accepted.
- p0 in WAIT, flush_i coincident with dataOk -> no p0_ok_o; IDLE next cycle. Same with owner p1 -> p1_ok_o delivered normally.
- Memory silent with TIMEOUT = 4 -> owner ok_o = 1, err_o = 1, data_o = 0 exactly TIMEOUT cycles after request; state IDLE.
- reset_n asserted while in WAIT, then released; stale dataOk arrives -> all outputs 0 during reset, no ok pulse after release, busy_o = 0.
